// File: rtl/exe_muldiv_if.sv
`timescale 1ns/1ps
// Issue/result bundle between the execute stage and the M-extension unit.
// The master side is the pipeline and the slave side is exe_muldiv.
interface exe_muldiv_if #(
  parameter int XLEN        = 32,
  parameter int RADDR_WIDTH = 5
);
  logic                   start_i;
  logic [2:0]             op_i;
  logic [XLEN-1:0]        op1_i;
  logic [XLEN-1:0]        op2_i;
  logic [RADDR_WIDTH-1:0] reg_waddr_i;
  logic                   flush_i;
  logic                   stallreq_o;
  logic                   busy_o;
  logic                   valid_o;
  logic                   reg_we_o;
  logic [XLEN-1:0]        result_o;
  logic [RADDR_WIDTH-1:0] reg_waddr_o;

  modport master (
    output start_i, op_i, op1_i, op2_i, reg_waddr_i, flush_i,
    input  stallreq_o, busy_o, valid_o, reg_we_o, result_o, reg_waddr_o
  );

  modport slave (
    input  start_i, op_i, op1_i, op2_i, reg_waddr_i, flush_i,
    output stallreq_o, busy_o, valid_o, reg_we_o, result_o, reg_waddr_o
  );
endinterface

// File: rtl/exe_muldiv.sv
`timescale 1ns/1ps
// RV32M multiply/divide unit: iterative shift-add multiply and restoring divide on magnitudes.
// Iterative ops finish XLEN+1 cycles after accept, short cases after 1; stallreq holds the pipe until DONE.
module exe_muldiv #(
  parameter int XLEN        = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int FAST_MUL    = 0
) (
  input logic         clk_i,
  input logic         rst_i,
  exe_muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [2:0]             op_q;
  logic                   neg_q;
  logic                   neg_r;
  logic [XLEN-1:0]        a_q;
  logic [2*XLEN-1:0]      b_q;
  logic [2*XLEN-1:0]      acc_q;
  logic [RADDR_WIDTH-1:0] waddr_q;
  logic [RADDR_WIDTH-1:0] waddr_out;
  logic [XLEN-1:0]        result_out;
  logic                   valid_out;
  logic                   busy_out;

  logic                   is_div, a_signed, b_signed, op1_neg, op2_neg;
  logic                   div_zero, div_ovf, short_case, accept;
  logic [XLEN-1:0]        mag1, mag2, short_res;
  logic [2*XLEN-1:0]      fast_mag, fast_prod;

  always_comb begin
    short_res  = '0;
    is_div     = bus.op_i[2];
    a_signed   = (bus.op_i == 3'b001) || (bus.op_i == 3'b010) || (is_div && !bus.op_i[0]);
    b_signed   = (bus.op_i == 3'b001) || (is_div && !bus.op_i[0]);
    op1_neg    = a_signed && bus.op1_i[XLEN-1];
    op2_neg    = b_signed && bus.op2_i[XLEN-1];
    mag1       = op1_neg ? -bus.op1_i : bus.op1_i;
    mag2       = op2_neg ? -bus.op2_i : bus.op2_i;
    div_zero   = (bus.op2_i == '0);
    div_ovf    = is_div && !bus.op_i[0] &&
                 (bus.op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op2_i == '1);
    short_case = is_div ? (div_zero || div_ovf) : (FAST_MUL != 0);
    fast_mag   = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
    fast_prod  = (op1_neg ^ op2_neg) ? -fast_mag : fast_mag;
    // Divide-by-zero and signed overflow have architecturally fixed results.
    if (is_div) begin
      if (div_zero) short_res = bus.op_i[1] ? bus.op1_i : '1;
      else          short_res = bus.op_i[1] ? '0 : bus.op1_i;
    end else if (bus.op_i[1:0] == 2'b00) begin
      short_res = fast_prod[XLEN-1:0];
    end else begin
      short_res = fast_prod[2*XLEN-1:XLEN];
    end
    accept = (state_q == IDLE) && bus.start_i && !bus.flush_i;
  end

  logic [XLEN:0]     r_shift;
  logic              ge;
  logic [XLEN-1:0]   a_n, q_fin, r_fin, res_fin;
  logic [2*XLEN-1:0] acc_n, b_n, prod;

  // One iteration: a_q is multiplier / dividend-then-quotient, b_q multiplicand / divisor.
  always_comb begin
    r_shift = {acc_q[XLEN-1:0], a_q[XLEN-1]};
    ge      = (r_shift >= {1'b0, b_q[XLEN-1:0]});
    if (op_q[2]) begin
      a_n   = {a_q[XLEN-2:0], ge};
      acc_n = {{XLEN{1'b0}}, ge ? (r_shift[XLEN-1:0] - b_q[XLEN-1:0]) : r_shift[XLEN-1:0]};
      b_n   = b_q;
    end else begin
      a_n   = a_q >> 1;
      acc_n = a_q[0] ? (acc_q + b_q) : acc_q;
      b_n   = b_q << 1;
    end
    prod  = neg_q ? -acc_n : acc_n;
    q_fin = neg_q ? -a_n : a_n;
    r_fin = neg_r ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
    if (op_q[2])                 res_fin = op_q[1] ? r_fin : q_fin;
    else if (op_q[1:0] == 2'b00) res_fin = prod[XLEN-1:0];
    else                         res_fin = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      waddr_q    <= '0;
      waddr_out  <= '0;
      result_out <= '0;
      valid_out  <= 1'b0;
      busy_out   <= 1'b0;
    end else if (bus.flush_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      waddr_out  <= '0;
      result_out <= '0;
      valid_out  <= 1'b0;
      busy_out   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= bus.op_i;
            waddr_q <= bus.reg_waddr_i;
            neg_q   <= op1_neg ^ op2_neg;
            neg_r   <= op1_neg;
            a_q     <= mag1;
            b_q     <= {{XLEN{1'b0}}, mag2};
            acc_q   <= '0;
            cnt_q   <= '0;
            if (short_case) begin
              state_q    <= DONE;
              valid_out  <= 1'b1;
              result_out <= short_res;
              waddr_out  <= bus.reg_waddr_i;
            end else begin
              state_q  <= BUSY;
              busy_out <= 1'b1;
            end
          end
        end
        BUSY: begin
          a_q   <= a_n;
          b_q   <= b_n;
          acc_q <= acc_n;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN-1)) begin
            state_q    <= DONE;
            busy_out   <= 1'b0;
            valid_out  <= 1'b1;
            result_out <= res_fin;
            waddr_out  <= waddr_q;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          cnt_q      <= '0;
          valid_out  <= 1'b0;
          result_out <= '0;
          waddr_out  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stallreq_o  = !rst_i && ((state_q == BUSY) || accept);
  assign bus.busy_o      = busy_out;
  assign bus.valid_o     = valid_out;
  assign bus.reg_we_o    = valid_out;
  assign bus.result_o    = result_out;
  assign bus.reg_waddr_o = waddr_out;
endmodule

// File: tb/tb_exe_muldiv.sv
`timescale 1ns/1ps
// Scoreboard bench: an iterative (FAST_MUL=0) and a single-cycle-multiply (FAST_MUL=1) unit
// checked against an arithmetic reference model with cycle-accurate completion times.
module tb_exe_muldiv;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic clk = 1'b0;
  logic rst_s, rst_f;
  always #5 clk = ~clk;

  exe_muldiv_if #(.XLEN(XLEN), .RADDR_WIDTH(RW)) bus_s ();
  exe_muldiv_if #(.XLEN(XLEN), .RADDR_WIDTH(RW)) bus_f ();

  exe_muldiv #(.XLEN(XLEN), .RADDR_WIDTH(RW), .FAST_MUL(0)) dut_s (.clk_i(clk), .rst_i(rst_s), .bus(bus_s));
  exe_muldiv #(.XLEN(XLEN), .RADDR_WIDTH(RW), .FAST_MUL(1)) dut_f (.clk_i(clk), .rst_i(rst_f), .bus(bus_f));

  typedef struct { logic [31:0] res; logic [4:0] waddr; int cyc; } exp_t;
  exp_t q_s[$];
  exp_t q_f[$];
  int errors = 0, checks = 0, cyc = 0, vcnt_s = 0, vcnt_f = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    p   = '0;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: if (b == 0) r = '1; else if (ovf) r = a; else begin p = sa / sb; r = p[31:0]; end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) r = a; else if (ovf) r = '0; else begin p = sa % sb; r = p[31:0]; end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input bit fast, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) return ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
    return fast ? 1 : 33;
  endfunction

  function automatic logic stall_of(input bit fast);
    return fast ? bus_f.stallreq_o : bus_s.stallreq_o;
  endfunction

  function automatic logic busy_of(input bit fast);
    return fast ? bus_f.busy_o : bus_s.busy_o;
  endfunction

  task automatic drive(input bit fast, input logic st, input logic fl, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
    if (fast) begin
      bus_f.start_i = st; bus_f.flush_i = fl; bus_f.op_i = op;
      bus_f.op1_i = a; bus_f.op2_i = b; bus_f.reg_waddr_i = wa;
    end else begin
      bus_s.start_i = st; bus_s.flush_i = fl; bus_s.op_i = op;
      bus_s.op1_i = a; bus_s.op2_i = b; bus_s.reg_waddr_i = wa;
    end
  endtask

  task automatic check_zero(input bit fast, input string name);
    if (fast) begin
      check({name, "_stall"}, 64'(bus_f.stallreq_o), 64'(0));
      check({name, "_busy"},  64'(bus_f.busy_o),     64'(0));
      check({name, "_valid"}, 64'(bus_f.valid_o),    64'(0));
      check({name, "_we"},    64'(bus_f.reg_we_o),   64'(0));
      check({name, "_res"},   64'(bus_f.result_o),   64'(0));
      check({name, "_waddr"}, 64'(bus_f.reg_waddr_o), 64'(0));
    end else begin
      check({name, "_stall"}, 64'(bus_s.stallreq_o), 64'(0));
      check({name, "_busy"},  64'(bus_s.busy_o),     64'(0));
      check({name, "_valid"}, 64'(bus_s.valid_o),    64'(0));
      check({name, "_we"},    64'(bus_s.reg_we_o),   64'(0));
      check({name, "_res"},   64'(bus_s.result_o),   64'(0));
      check({name, "_waddr"}, 64'(bus_s.reg_waddr_o), 64'(0));
    end
  endtask

  task automatic monitor_one(input bit fast, input logic v, input logic we,
                             input logic [31:0] res, input logic [4:0] wa);
    exp_t e;
    int   pending;
    check(fast ? "f_we_vs_valid" : "s_we_vs_valid", 64'(we), 64'(v));
    if (v === 1'b1) begin
      if (fast) vcnt_f++; else vcnt_s++;
      pending = fast ? q_f.size() : q_s.size();
      if (pending == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_valid: got valid with result 0x%0h, required no valid (cycle %0d)",
                 fast ? "f" : "s", res, cyc);
      end else begin
        if (fast) e = q_f.pop_front(); else e = q_s.pop_front();
        check(fast ? "f_result" : "s_result", 64'(res), 64'(e.res));
        check(fast ? "f_waddr" : "s_waddr", 64'(wa), 64'(e.waddr));
        check(fast ? "f_done_cycle" : "s_done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else begin
      check(fast ? "f_idle_result" : "s_idle_result", 64'(res), 64'(0));
      check(fast ? "f_idle_waddr" : "s_idle_waddr", 64'(wa), 64'(0));
    end
  endtask

  always @(negedge clk) begin
    if (!rst_s) monitor_one(1'b0, bus_s.valid_o, bus_s.reg_we_o, bus_s.result_o, bus_s.reg_waddr_o);
    if (!rst_f) monitor_one(1'b1, bus_f.valid_o, bus_f.reg_we_o, bus_f.result_o, bus_f.reg_waddr_o);
  end

  // Called just after a rising edge; start_i is high for exactly this cycle.
  task automatic run_op(input bit fast, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa, input logic [31:0] exp_res);
    exp_t e;
    int   t, lat;
    lat     = exp_lat(fast, op, a, b);
    t       = cyc;
    e.res   = exp_res;
    e.waddr = wa;
    e.cyc   = t + lat;
    if (fast) q_f.push_back(e); else q_s.push_back(e);
    drive(fast, 1'b1, 1'b0, op, a, b, wa);
    @(negedge clk);
    check("stall_accept", 64'(stall_of(fast)), 64'(1));
    @(posedge clk);
    #1;
    drive(fast, 1'b0, 1'b0, 3'($urandom), $urandom, $urandom, 5'($urandom));
    for (int k = 0; k < 100; k++) begin
      if ((fast ? q_f.size() : q_s.size()) == 0) break;
      @(negedge clk);
      check("stall_window", 64'(stall_of(fast)), 64'(cyc < t + lat));
      check("busy_window", 64'(busy_of(fast)), 64'((lat > 1) && (cyc < t + lat)));
    end
    if ((fast ? q_f.size() : q_s.size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: op %0d no valid_o by cycle %0d, required at cycle %0d", op, cyc, t + lat);
      if (fast) q_f.delete(); else q_s.delete();
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 8))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int t0, vc;
    logic [2:0] op;
    logic [31:0] a, b;
    bit fast;
    rst_s = 1'b0;
    rst_f = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    #1;
    rst_s = 1'b1;
    rst_f = 1'b1;
    #1;
    check_zero(1'b0, "reset_s");
    check_zero(1'b1, "reset_f");
    repeat (2) @(posedge clk);
    #1;
    rst_s = 1'b0;
    rst_f = 1'b0;

    align(); run_op(1'b0, 3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB);
    align(); run_op(1'b0, 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE);
    align(); run_op(1'b0, 3'd1, 32'h8000_0000,  32'h8000_0000, 5'd3,  32'h4000_0000);
    align(); run_op(1'b0, 3'd2, 32'hFFFF_FFFF,  32'd2,         5'd4,  32'hFFFF_FFFF);
    align(); run_op(1'b0, 3'd4, 32'hFFFF_FFF9,  32'd2,         5'd5,  32'hFFFF_FFFD);
    align(); run_op(1'b0, 3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF);
    align(); run_op(1'b0, 3'd5, 32'd100,        32'd7,         5'd7,  32'd14);
    align(); run_op(1'b0, 3'd7, 32'd100,        32'd7,         5'd8,  32'd2);
    align(); run_op(1'b0, 3'd4, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF);
    align(); run_op(1'b0, 3'd6, 32'd5,          32'd0,         5'd10, 32'd5);
    align(); run_op(1'b0, 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
    align(); run_op(1'b0, 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0);
    align(); run_op(1'b1, 3'd0, 32'd7,          32'hFFFF_FFFD, 5'd13, 32'hFFFF_FFEB);
    align(); run_op(1'b1, 3'd1, 32'h8000_0000,  32'h8000_0000, 5'd14, 32'h4000_0000);
    align(); run_op(1'b1, 3'd5, 32'd100,        32'd7,         5'd15, 32'd14);

    // Flush mid-operation, then a fresh start right after.
    align();
    t0 = cyc;
    drive(1'b0, 1'b1, 1'b0, 3'd5, 32'd100, 32'd7, 5'd16);
    align();
    drive(1'b0, 1'b0, 1'b0, 3'd5, 32'd100, 32'd7, 5'd16);
    repeat (9) align();
    drive(1'b0, 1'b0, 1'b1, 3'd5, 32'd100, 32'd7, 5'd16);
    align();
    drive(1'b0, 1'b0, 1'b0, 3'd5, 32'd100, 32'd7, 5'd16);
    check("flush_at_cycle", 64'(cyc), 64'(t0 + 11));
    check("flush_busy", 64'(bus_s.busy_o), 64'(0));
    check("flush_valid", 64'(bus_s.valid_o), 64'(0));
    run_op(1'b0, 3'd5, 32'd1000, 32'd9, 5'd17, 32'd111);

    // Flush and start together: start must be dropped.
    align();
    drive(1'b0, 1'b1, 1'b1, 3'd7, 32'd100, 32'd7, 5'd18);
    @(negedge clk);
    check("flush_start_stall", 64'(bus_s.stallreq_o), 64'(0));
    align();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    check("flush_start_busy", 64'(bus_s.busy_o), 64'(0));
    repeat (3) align();

    // Asynchronous reset mid-operation, then a start on the first edge after release.
    align();
    drive(1'b0, 1'b1, 1'b0, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd19);
    repeat (5) align();
    rst_s = 1'b1;
    #1;
    check_zero(1'b0, "rst_mid");
    #1;
    rst_s = 1'b0;
    run_op(1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 32'hFFFF_FFFE);

    // start_i held through DONE yields exactly one result.
    align();
    t0 = cyc;
    vc = vcnt_s;
    q_s.push_back('{res: 32'd14, waddr: 5'd21, cyc: t0 + 33});
    drive(1'b0, 1'b1, 1'b0, 3'd5, 32'd100, 32'd7, 5'd21);
    repeat (34) align();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    repeat (4) align();
    check("held_start_valids", 64'(vcnt_s - vc), 64'(1));
    check("held_start_pending", 64'(q_s.size()), 64'(0));

    for (int i = 0; i < 24; i++) begin
      op   = 3'($urandom_range(0, 7));
      a    = pick();
      b    = pick();
      fast = (i % 3 == 0);
      align();
      run_op(fast, op, a, b, 5'($urandom), ref_model(op, a, b));
    end

    repeat (3) align();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
